timer_seq_ctrl: RTL
===================

Name: timer_seq_ctrl

Overview:
- Avalon-MM master sequencer that owns the 16-bit-data interval timer slave (3-bit word address, registered readdata, no waitrequest).
- Turns three kinds of request into timer bus transactions:
  - a 32-bit period/mode reconfiguration from a client,
  - a counter-snapshot read,
  - automatic servicing of timer interrupts, which clears status and emits a tick pulse.
- Sits between system control logic and the timer so software-free subsystems can use the timer.

Parameters:
- DEFAULT_PERIOD, 32'd49999: period loaded by the automatic configuration after reset.
- AUTO_START, 1: 1 = run one configuration (DEFAULT_PERIOD, continuous, irq enabled) right after reset; 0 = stay idle.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tmr_address  out  3  timer word address
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write strobe, active low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data, valid 1 cycle after address
- tmr_irq  in  1  timer interrupt, level
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted this cycle
- cfg_period  in  32  requested period
- cfg_continuous  in  1  continuous mode
- cfg_irq_en  in  1  interrupt enable
- snap_valid  in  1  snapshot request
- snap_ready  out  1  snapshot accepted this cycle
- snap_done  out  1  one-cycle pulse, snap_value valid
- snap_value  out  32  captured counter value
- tick  out  1  one-cycle pulse per serviced timeout
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - FSM enters IDLE, or AUTO if AUTO_START=1.
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
  - cfg_ready=0, snap_ready=0, snap_done=0, tick=0, busy=0, snap_value=0.
- Output registering:
  - All timer outputs are registered.
  - A transaction occupies exactly one cycle with chipselect=1.
  - Between transactions, chipselect=0 and write_n=1.
- Timer register map (word addresses):
  - 0 = status; a write clears the timeout.
  - 1 = control: bit0 ito, bit1 cont, bit2 start, bit3 stop.
  - 2 = period_l, 3 = period_h.
  - 4 = snap_l, 5 = snap_h; a write latches a snapshot.
- IDLE arbitration, fixed priority:
  1. tmr_irq=1 → CLR_IRQ
  2. cfg_valid → WR_PL
  3. snap_valid → SNAP_W
- cfg_ready / snap_ready pulse for one cycle in the cycle the request is taken from IDLE. The payload (cfg_period, cfg_continuous, cfg_irq_en) is latched in that cycle.
- Period rule: a requested period of 0 is replaced by 1.
- Configuration sequence, one cycle each, then back to IDLE:
  - WR_PL: address 2, data period[15:0].
  - WR_PH: address 3, data period[31:16].
  - WR_ST: address 0, data 0; clears any stale timeout.
  - WR_CTRL: address 1, data {12'b0, 1'b0, 1'b1, cont, irq_en}.
  - Latency from cfg_valid accepted to the control write is 4 cycles.
- AUTO state: runs the configuration sequence with DEFAULT_PERIOD, cont=1, irq_en=1. It does not pulse cfg_ready.
- Interrupt service:
  - CLR_IRQ: write address 0, data 0; tick pulses in the same cycle; then IDLE.
  - The timer deasserts irq the cycle after the write, so IDLE sees irq low.
  - A timeout that coincides with the status write is lost, matching timer semantics.
- Snapshot sequence:
  - SNAP_W: write address 4, data 0.
  - SNAP_RL: chipselect=0, address 4.
  - SNAP_RH: address 5; capture tmr_readdata as the low half.
  - SNAP_CAP: capture tmr_readdata as the high half.
  - snap_done=1 with the updated snap_value in the cycle after SNAP_CAP, then IDLE.
  - Total: 5 cycles from acceptance to snap_done.
- No preemption: an irq arriving mid-sequence is serviced at the next IDLE. The irq level persists, so it is not lost.
- Requests held during busy are honoured when IDLE returns. Both requests held → configuration first.
- Reset mid-sequence:
  - All outputs return to reset values.
  - The timer may be left partially programmed.
  - With AUTO_START=1, reprogramming is complete after reset.

Optional Feature:
- Macro: TIMER_SEQ_TICK_COUNT_EN.
- Defined:
  - Adds output tick_count[31:0], reset 0.
  - Increments by 1 on every tick, wrapping 0xFFFFFFFF→0.
  - Cleared to 0 in the WR_CTRL cycle of every configuration sequence; if a tick coincides with that cycle, the clear wins.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, AUTO_START=1, DEFAULT_PERIOD=49999 → writes in order: addr2=0xC34F, addr3=0x0000, addr0=0x0000, addr1=0x0007; busy then 0; cfg_ready never 1.
- cfg_valid with period=0x0001_86A0, cont=0, irq_en=1 → cfg_ready 1 cycle; writes addr2=0x86A0, addr3=0x0001, addr0=0, addr1=0x0005.
- cfg_period=0 → addr2=0x0001, addr3=0x0000.
- tmr_irq raised and held until the status write → exactly one addr0 write, one tick pulse; a second irq 10 cycles later → a second tick.
- Model tmr_readdata as registered mux with snapshot 0x1234_5678, then snap_valid → write addr4, snap_done 5 cycles after snap_ready, snap_value=0x12345678.
- cfg_valid, snap_valid and tmr_irq in the same IDLE cycle → order CLR_IRQ, config sequence, snapshot. With TIMER_SEQ_TICK_COUNT_EN: tick_count=1, then 0 after WR_CTRL.

Source files
------------

// File: rtl/timer_seq_ctrl_if.sv
// Avalon-MM bus between the sequencer (master) and the 16-bit interval timer (slave).
interface timer_seq_ctrl_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_readdata, tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_readdata, tmr_irq
  );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Avalon-MM sequencer driving the interval timer: configuration, snapshot reads, irq service.
// Optional macro TIMER_SEQ_TICK_COUNT_EN adds a tick_count output cleared by each configuration.
module timer_seq_ctrl #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  timer_seq_ctrl_if.master        tmr,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [31:0]             cfg_period,
  input  logic                    cfg_continuous,
  input  logic                    cfg_irq_en,
  input  logic                    snap_valid,
  output logic                    snap_ready,
  output logic                    snap_done,
  output logic [31:0]             snap_value,
  output logic                    tick,
  output logic                    busy
`ifdef TIMER_SEQ_TICK_COUNT_EN
  ,
  output logic [31:0]             tick_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_AUTO, S_WR_PL, S_WR_PH, S_WR_ST, S_WR_CTRL,
    S_CLR_IRQ, S_SNAP_W, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? S_AUTO : S_IDLE;

  state_t      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        cont_q, cont_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic        snap_done_q, snap_done_d;
  logic        tick_q, tick_d;
  logic        busy_q, busy_d;
  logic [2:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [15:0] wdata_q, wdata_d;

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    cont_d       = cont_q;
    irq_en_d     = irq_en_q;
    snap_lo_d    = snap_lo_q;
    snap_value_d = snap_value_q;
    snap_done_d  = 1'b0;
    cfg_ready    = 1'b0;
    snap_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tmr.tmr_irq) begin
          state_d = S_CLR_IRQ;
        end else if (cfg_valid) begin
          cfg_ready = 1'b1;
          period_d  = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
          cont_d    = cfg_continuous;
          irq_en_d  = cfg_irq_en;
          state_d   = S_WR_PL;
        end else if (snap_valid) begin
          snap_ready = 1'b1;
          state_d    = S_SNAP_W;
        end
      end
      S_AUTO: begin
        period_d = (DEFAULT_PERIOD == 32'd0) ? 32'd1 : DEFAULT_PERIOD;
        cont_d   = 1'b1;
        irq_en_d = 1'b1;
        state_d  = S_WR_PL;
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_ST;
      S_WR_ST:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_IDLE;
      S_CLR_IRQ: state_d = S_IDLE;
      S_SNAP_W:  state_d = S_SNAP_RL;
      S_SNAP_RL: state_d = S_SNAP_RH;
      S_SNAP_RH: begin
        // readdata now reflects the snap_l address presented last cycle
        snap_lo_d = tmr.tmr_readdata;
        state_d   = S_SNAP_CAP;
      end
      S_SNAP_CAP: begin
        snap_value_d = {tmr.tmr_readdata, snap_lo_q};
        snap_done_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the state being entered so they line up with state_q.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    tick_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);

    case (state_d)
      S_WR_PL:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];  end
      S_WR_PH:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16]; end
      S_WR_ST:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wdata_d = 16'd0;           end
      S_WR_CTRL:  begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
        wdata_d = {12'b0, 1'b0, 1'b1, cont_d, irq_en_d};
      end
      S_CLR_IRQ:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wdata_d = 16'd0; tick_d = 1'b1; end
      S_SNAP_W:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; wdata_d = 16'd0;           end
      S_SNAP_RL:  addr_d = 3'd4;
      S_SNAP_RH,
      S_SNAP_CAP: addr_d = 3'd5;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_STATE;
      period_q     <= 32'd0;
      cont_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      snap_lo_q    <= 16'd0;
      snap_value_q <= 32'd0;
      snap_done_q  <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= 3'd0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wdata_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      irq_en_q     <= irq_en_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_done_q  <= snap_done_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      wdata_q      <= wdata_d;
    end
  end

`ifdef TIMER_SEQ_TICK_COUNT_EN
  logic [31:0] tick_count_q, tick_count_d;

  // A configuration clears the count; the clear takes precedence over a tick.
  always_comb begin
    tick_count_d = tick_count_q;
    if (state_d == S_WR_CTRL)
      tick_count_d = 32'd0;
    else if (tick_d)
      tick_count_d = tick_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_count_q <= 32'd0;
    else          tick_count_q <= tick_count_d;
  end

  assign tick_count = tick_count_q;
`endif

  assign tmr.tmr_address    = addr_q;
  assign tmr.tmr_chipselect = cs_q;
  assign tmr.tmr_write_n    = wn_q;
  assign tmr.tmr_writedata  = wdata_q;
  assign snap_done          = snap_done_q;
  assign snap_value         = snap_value_q;
  assign tick               = tick_q;
  assign busy               = busy_q;

endmodule
